// File: rtl/dcount_pkg.sv
// Shared encodings and helpers for the dcount_gen loadable up/down counter.
// Every vector in this slice is declared [msb:0], so index 0 is the LSB.
package dcount_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_RELOAD  = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    localparam int MAX_WIDTH = 32;

    // Mask with the low 'width' bits set; callers cast it down to their own width.
    function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
        logic [MAX_WIDTH-1:0] mask_v;
        mask_v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                mask_v[i] = 1'b1;
            end else begin
                mask_v[i] = 1'b0;
            end
        end
        return mask_v;
    endfunction

endpackage

// File: rtl/dcount_step.sv
// Combinational +/-1 stepper: one half-adder ripple serves both directions
// by inverting the carry-propagate term when counting down.
module dcount_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             down,
    output logic [WIDTH-1:0] next_count,
    output logic             term
);

    logic carry_s;

    // Ripple: the carry (or borrow) out of the top bit marks the terminal value.
    always_comb begin
        carry_s    = 1'b1;
        next_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            next_count[i] = count[i] ^ carry_s;
            carry_s       = carry_s & (count[i] ^ down);
        end
        term = carry_s;
    end

endmodule

// File: rtl/dcount_gen.sv
// Parametrised loadable up/down counter with reload register, four
// terminal-count modes, registered tc pulse and run/zero status.
module dcount_gen
    import dcount_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             ena,
    input  logic             down,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] rld_data,
    input  logic             rld_we,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero,
    output logic             run
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] reload_r;
    logic             tc_r;
    logic             run_r;

    logic [WIDTH-1:0] step_s;
    logic             term_s;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] reload_nxt_s;
    logic             tc_nxt_s;
    logic             run_nxt_s;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    dcount_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .count     (count_r),
        .down      (down),
        .next_count(step_s),
        .term      (term_s)
    );

    // Next-state: load beats stepping; a reload write never touches count.
    always_comb begin
        count_nxt_s  = count_r;
        run_nxt_s    = run_r;
        tc_nxt_s     = 1'b0;
        reload_nxt_s = rld_we ? rld_data : reload_r;
        if (load) begin
            count_nxt_s = data;
            run_nxt_s   = 1'b1;
        end else if (ena && run_r) begin
            if (term_s) begin
                tc_nxt_s = 1'b1;
                case (mode_s)
                    MODE_WRAP:    count_nxt_s = down ? ALL_ONES : '0;
                    MODE_SAT:     count_nxt_s = count_r;
                    // Old reload value is used even if it is rewritten this cycle.
                    MODE_RELOAD:  count_nxt_s = reload_r;
                    MODE_ONESHOT: run_nxt_s   = 1'b0;
                    default:      count_nxt_s = count_r;
                endcase
            end else begin
                count_nxt_s = step_s;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State registers; reset also discards any tc that was about to be shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= RESET_VAL;
            reload_r <= RESET_VAL;
            tc_r     <= 1'b0;
            run_r    <= 1'b1;
        end else begin
            count_r  <= count_nxt_s;
            reload_r <= reload_nxt_s;
            tc_r     <= tc_nxt_s;
            run_r    <= run_nxt_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign run   = run_r;
    assign zero  = (count_r == '0);

endmodule
